// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared FSM states and cache address layout for the cache controller and data cache
package cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    localparam logic [31:0] CACHE_BASE_ADDR = 32'd1024;

    localparam int CACHE_ADDR_W = 19;
    localparam int TAG_W        = 10;
    localparam int INDEX_W      = 6;
    localparam int OFFSET_W     = 3;

    localparam int OFFSET_LSB   = 0;
    localparam int INDEX_LSB    = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB      = INDEX_LSB + INDEX_W;

    // Selects the upper or lower 32-bit word of a 64-bit line.
    localparam int WORD_SEL_BIT = 2;

endpackage

// File: rtl/cache_stats.sv
// rtl/cache_stats.sv - hit/miss statistics counters, built only when CACHE_CTRL_STATS_EN is defined
module cache_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit_inc)
                hit_count <= hit_count + 32'd1;
            if (miss_inc)
                miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - MEM-stage cache/SRAM control FSM; statistics enabled by CACHE_CTRL_STATS_EN
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CACHE_BASE_ADDR,
    parameter int          CADDR_W   = CACHE_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [CADDR_W-1:0] cache_addr,
    output logic               cache_read,
    output logic               cache_write,
    output logic               cache_mem_write,
    output logic [63:0]        cache_wdata,
    input  logic               cache_hit,
    input  logic [31:0]        cache_rdata,
    output logic               sram_r_en,
    output logic               sram_w_en,
    output logic [31:0]        sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
);

    state_t state;
    state_t state_next;

    logic [31:0] rel_addr;

    assign rel_addr    = address - BASE_ADDR;
    assign sram_addr   = rel_addr;
    assign cache_addr  = rel_addr[CADDR_W-1:0];
    assign sram_wdata  = wdata;
    assign cache_wdata = sram_rdata;

    // Enables come straight from the state register so they never glitch on cache_hit.
    assign sram_r_en = (state == READ_MISS);
    assign sram_w_en = (state == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next      = state;
        ready           = 1'b1;
        rdata           = 32'd0;
        cache_read      = 1'b0;
        cache_write     = 1'b0;
        cache_mem_write = 1'b0;
        // While reset is held the pipeline is released and every strobe stays quiet.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        cache_mem_write = 1'b1;
                        ready           = 1'b0;
                        state_next      = WRITE;
                    end else if (mem_r_en) begin
                        if (cache_hit) begin
                            cache_read = 1'b1;
                            rdata      = cache_rdata;
                        end else begin
                            ready      = 1'b0;
                            state_next = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    ready = 1'b0;
                    if (sram_ready) begin
                        cache_write = 1'b1;
                        rdata       = rel_addr[WORD_SEL_BIT] ? sram_rdata[63:32] : sram_rdata[31:0];
                        ready       = 1'b1;
                        state_next  = IDLE;
                    end
                end
                WRITE: begin
                    ready = 1'b0;
                    if (sram_ready) begin
                        ready      = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state == IDLE) && mem_r_en && !mem_w_en && cache_hit;
    assign miss_inc = (state == IDLE) && mem_r_en && !mem_w_en && !cache_hit;

    cache_stats u_cache_stats (
        .clk        (clk),
        .rst        (rst),
        .hit_inc    (hit_inc),
        .miss_inc   (miss_inc),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller with a load-data scoreboard
module tb_cache_controller;

`ifdef CACHE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [18:0] cache_addr;
    logic        cache_read, cache_write, cache_mem_write;
    logic [63:0] cache_wdata;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        sram_r_en, sram_w_en;
    logic [31:0] sram_addr, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [31:0] hit_count, miss_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cache_controller dut (
        .clk             (clk),
        .rst             (rst),
        .mem_r_en        (mem_r_en),
        .mem_w_en        (mem_w_en),
        .address         (address),
        .wdata           (wdata),
        .rdata           (rdata),
        .ready           (ready),
        .cache_addr      (cache_addr),
        .cache_read      (cache_read),
        .cache_write     (cache_write),
        .cache_mem_write (cache_mem_write),
        .cache_wdata     (cache_wdata),
        .cache_hit       (cache_hit),
        .cache_rdata     (cache_rdata),
        .sram_r_en       (sram_r_en),
        .sram_w_en       (sram_w_en),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata),
        .sram_ready      (sram_ready),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_load(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, {32'd0, obs}, {32'd0, exp});
        end
    endtask

    // Runs the SRAM phase after a detect cycle; sram_ready fires in wait cycle n_wait.
    task automatic run_txn(input int n_wait, output int low, output int fills, output int rd_cyc,
                           output int wr_cyc, output int inv_cyc, output logic [31:0] rd, output bit done);
        low = 1; fills = 0; rd_cyc = 0; wr_cyc = 0; inv_cyc = 0; rd = 32'd0; done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge clk);
            sram_ready = (c == n_wait);
            #1;
            fills   += int'(cache_write);
            rd_cyc  += int'(sram_r_en);
            wr_cyc  += int'(sram_w_en);
            inv_cyc += int'(cache_mem_write);
            if (ready) begin
                done = 1'b1;
                rd   = rdata;
            end else begin
                low++;
            end
        end
        @(negedge clk);
        sram_ready = 1'b0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        #1;
    endtask

    initial begin
        int low, fills, rd_cyc, wr_cyc, inv_cyc;
        logic [31:0] rd;
        bit done;

        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'h410; wdata = 32'd0;
        cache_hit = 1'b0; cache_rdata = 32'd0; sram_rdata = 64'd0; sram_ready = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_sram_r_en", sram_r_en, 0);
        chk("rst_sram_w_en", sram_w_en, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {cache_read, cache_write, cache_mem_write}, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ready", ready, 1);

        // Load miss at 0x410, line returns after three wait cycles.
        @(negedge clk);
        mem_r_en = 1'b1; address = 32'h410; cache_hit = 1'b0;
        sram_rdata = 64'hAAAA_BBBB_1111_2222;
        exp_q.push_back(32'h1111_2222);
        #1;
        chk("miss_detect_ready", ready, 0);
        chk("miss_cache_addr", cache_addr, 19'h10);
        chk("miss_sram_addr", sram_addr, 32'h10);
        chk("miss_detect_no_sram_r_en", sram_r_en, 0);
        chk("miss_detect_no_read", cache_read, 0);
        run_txn(3, low, fills, rd_cyc, wr_cyc, inv_cyc, rd, done);
        chk("miss_done", done, 1);
        chk("miss_low_cycles", low, 4);
        chk("miss_fills", fills, 1);
        chk("miss_sram_r_en_cycles", rd_cyc, 4);
        chk("miss_sram_w_en_cycles", wr_cyc, 0);
        chk_load("miss_rdata", rd);
        chk("miss_after_sram_r_en", sram_r_en, 0);
        chk("miss_count_1", miss_count, STATS ? 1 : 0);
        chk("miss_hit_count_0", hit_count, 0);

        // Load hit at 0x414: zero stall.
        @(negedge clk);
        mem_r_en = 1'b1; address = 32'h414; cache_hit = 1'b1; cache_rdata = 32'hAAAA_BBBB;
        exp_q.push_back(32'hAAAA_BBBB);
        #1;
        chk("hit_ready", ready, 1);
        chk("hit_cache_read", cache_read, 1);
        chk("hit_no_fill", cache_write, 0);
        chk_load("hit_rdata", rdata);
        @(negedge clk);
        mem_r_en = 1'b0; cache_hit = 1'b0;
        #1;
        chk("hit_sram_r_en", sram_r_en, 0);
        chk("hit_count_1", hit_count, STATS ? 1 : 0);
        chk("hit_miss_count", miss_count, STATS ? 1 : 0);

        // Store DEAD_BEEF to 0x410 (line present, so cache invalidates).
        @(negedge clk);
        mem_w_en = 1'b1; address = 32'h410; wdata = 32'hDEAD_BEEF; cache_hit = 1'b1;
        #1;
        chk("st_inval", cache_mem_write, 1);
        chk("st_detect_ready", ready, 0);
        chk("st_sram_addr", sram_addr, 32'h10);
        chk("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("st_hit_no_read", cache_read, 0);
        run_txn(1, low, fills, rd_cyc, wr_cyc, inv_cyc, rd, done);
        chk("st_done", done, 1);
        chk("st_low_cycles", low, 2);
        chk("st_sram_w_en_cycles", wr_cyc, 2);
        chk("st_sram_r_en_cycles", rd_cyc, 0);
        chk("st_inval_in_wait", inv_cyc, 0);
        chk("st_no_fill", fills, 0);
        chk("st_hit_count", hit_count, STATS ? 1 : 0);
        cache_hit = 1'b0;

        // Load and store together behave as a store.
        @(negedge clk);
        mem_r_en = 1'b1; mem_w_en = 1'b1; address = 32'h420; wdata = 32'h1234_5678;
        #1;
        chk("both_inval", cache_mem_write, 1);
        chk("both_ready", ready, 0);
        run_txn(0, low, fills, rd_cyc, wr_cyc, inv_cyc, rd, done);
        chk("both_done", done, 1);
        chk("both_low_cycles", low, 1);
        chk("both_sram_r_en_cycles", rd_cyc, 0);
        chk("both_sram_w_en_cycles", wr_cyc, 1);
        chk("both_miss_count", miss_count, STATS ? 1 : 0);

        // Address below the base wraps.
        @(negedge clk);
        address = 32'h0;
        #1;
        chk("wrap_cache_addr", cache_addr, 19'h7FC00);
        chk("wrap_sram_addr", sram_addr, 32'hFFFF_FC00);

        // sram_ready with no transaction is ignored.
        @(negedge clk);
        sram_ready = 1'b1; sram_rdata = 64'h5555_6666_7777_8888;
        #1;
        chk("idle_sramrdy_ready", ready, 1);
        chk("idle_sramrdy_fill", cache_write, 0);
        chk("idle_sramrdy_rdata", rdata, 0);
        @(negedge clk);
        sram_ready = 1'b0;
        #1;
        chk("idle_sramrdy_enables", {sram_r_en, sram_w_en}, 0);

        // Reset in the middle of a READ_MISS.
        @(negedge clk);
        mem_r_en = 1'b1; address = 32'h418; cache_hit = 1'b0;
        #1;
        chk("rmr_detect_ready", ready, 0);
        @(negedge clk);
        #1;
        chk("rmr_in_miss", sram_r_en, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rmr_sram_r_en_drop", sram_r_en, 0);
        chk("rmr_ready", ready, 1);
        chk("rmr_miss_count", miss_count, 0);
        @(negedge clk);
        rst = 1'b0; mem_r_en = 1'b0;
        #1;
        chk("rmr_idle_ready", ready, 1);
        chk("rmr_idle_sram_r_en", sram_r_en, 0);

        // Back-to-back hits after the abort.
        @(negedge clk);
        mem_r_en = 1'b1; address = 32'h41C; cache_hit = 1'b1; cache_rdata = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        #1;
        chk("b2b_ready", ready, 1);
        chk_load("b2b_rdata", rdata);
        @(negedge clk);
        address = 32'h418; cache_rdata = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
        #1;
        chk_load("b2b2_rdata", rdata);
        @(negedge clk);
        mem_r_en = 1'b0; cache_hit = 1'b0;
        #1;
        chk("b2b_hit_count", hit_count, STATS ? 2 : 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Control stage between the MEM pipeline stage and the 2-way set-associative data cache / SRAM controller. Decodes MEM-stage load/store requests, serves load hits from the cache in the same cycle, and refills a 64-bit line from SRAM on a load miss. Stores are write-through, no-allocate: the matching cache line is invalidated and the word is written to SRAM. Holds `ready` low to freeze the pipeline while an SRAM transaction is outstanding.

## Interface
- `BASE_ADDR`, 1024, byte address subtracted from the CPU address before cache/SRAM indexing
- `CADDR_W`, 19, cache address width (10 tag, 6 index, 3 offset)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_r_en`  in  1  MEM-stage load request
- `mem_w_en`  in  1  MEM-stage store request
- `address`  in  32  CPU byte address, word aligned
- `wdata`  in  32  store data
- `rdata`  out  32  load data, valid when `ready`=1 and `mem_r_en`=1
- `ready`  out  1  0 freezes pipeline; request inputs held stable while 0
- `cache_addr`  out  19  `(address - BASE_ADDR)[18:0]`
- `cache_read`  out  1  hit-read strobe (LRU update)
- `cache_write`  out  1  line fill strobe
- `cache_mem_write`  out  1  invalidate-on-store strobe
- `cache_wdata`  out  64  fill line, equals `sram_rdata`
- `cache_hit`  in  1  combinational hit from cache
- `cache_rdata`  in  32  combinational hit data from cache
- `sram_r_en`, `sram_w_en`  out  1  SRAM line read / word write request
- `sram_addr`  out  32  `address - BASE_ADDR`
- `sram_wdata`  out  32  equals `wdata`
- `sram_rdata`  in  64  line data, `{word1, word0}`, valid with `sram_ready`
- `sram_ready`  in  1  one-cycle completion pulse from SRAM controller
- `hit_count`, `miss_count`  out  32  statistics, see Configuration

## Operation
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE, `mem_r_en` & `cache_hit`: `cache_read`=1, `rdata`=`cache_rdata`, `ready`=1, stay IDLE.
- IDLE, `mem_r_en` & ~`cache_hit`: `ready`=0, next READ_MISS.
- IDLE, `mem_w_en`: `cache_mem_write`=1 (cache invalidates only on hit), `ready`=0, next WRITE.
- `mem_r_en` & `mem_w_en` together: treated as store.
- No request in IDLE: `ready`=1, all strobes 0.
- READ_MISS: `sram_r_en`=1, `ready`=0 until `sram_ready`. On `sram_ready`: `cache_write`=1, `cache_wdata`=`sram_rdata`, `rdata`=`sram_rdata[63:32]` if `cache_addr[2]` else `[31:0]`, `ready`=1, next IDLE.
- WRITE: `sram_w_en`=1, `ready`=0 until `sram_ready`; on `sram_ready`, `ready`=1, next IDLE.
- `sram_ready` in IDLE is ignored.
- Address arithmetic is modulo 2^32; addresses below `BASE_ADDR` wrap, no error.

## Timing
- Reset: state IDLE; `ready`=1, all strobes and SRAM enables 0, `rdata`=0 when no request, counters 0. Asserting `rst` mid-transaction aborts immediately; SRAM enables drop asynchronously.
- Load hit: 0 stall cycles, `ready` combinational.
- Load miss: 1 detect cycle + N SRAM cycles; `ready` rises in the cycle `sram_ready` is seen. With `sram_ready` in the first READ_MISS cycle, total 2 cycles.
- Store: same latency shape as a miss; `cache_mem_write` only in the IDLE detect cycle.
- SRAM enables are decoded from the state register only (glitch-free, no dependence on `cache_hit`).
- Back-to-back requests: a new request is accepted in the IDLE cycle after completion.

## Configuration
- `CACHE_CTRL_STATS_EN` defined: `hit_count` increments on each IDLE load hit; `miss_count` increments on each READ_MISS entry; both wrap at 2^32.
- Undefined: counter logic is not built; `hit_count`, `miss_count` tied to 0.

## Structure
- Shared package: state enum (IDLE, READ_MISS, WRITE), `BASE_ADDR`, tag/index/offset widths and field positions, shared with the cache.
- FSM and datapath muxing in one module; sub-module `cache_stats` (two 32-bit counters) instantiated only under `CACHE_CTRL_STATS_EN`.

## Test plan
- Reset mid-READ_MISS -> `sram_r_en` drops within the reset cycle, `ready`=1, state IDLE.
- Load 0x410 miss, `sram_ready` after 3 cycles with `sram_rdata`=0xAAAA_BBBB_1111_2222 -> `ready` low 4 cycles, `cache_write`=1 once, `rdata`=0x1111_2222; with `CACHE_CTRL_STATS_EN`, `miss_count`=1.
- Repeat load 0x414 with `cache_hit`=1, `cache_rdata`=0xAAAA_BBBB -> `ready`=1 same cycle, `cache_read`=1, `rdata`=0xAAAA_BBBB; `hit_count`=1.
- Store 0xDEAD_BEEF to 0x410 -> `cache_mem_write` pulses 1 cycle, `sram_w_en`=1 with `sram_addr`=0x10, `sram_wdata`=0xDEAD_BEEF until `sram_ready`.
- `mem_r_en`=`mem_w_en`=1 -> store sequence only, no `sram_r_en`.
- Address 0x0 -> `cache_addr`=0x7FC00, `sram_addr`=0xFFFF_FC00.
